product_accumulator: RTL

- Downstream stage of the combinational 32x32 signed Booth multiplier: consumes its 64-bit signed product stream and reduces each block of products to one signed sum (dot product / MAC).
- Valid/ready handshake on both sides; a one-entry result buffer decouples the accumulator from the consumer.
- Detects signed overflow; the sum either wraps or saturates, selected by a parameter.

---
 rtl/arith_pkg.sv | 23 ++
 rtl/sat_adder.sv | 29 ++
 rtl/product_accumulator.sv | 96 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths, accumulator state type and signed limit helpers
package arith_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 80;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Largest positive two's-complement value at width w (w <= 128), zero-extended.
  function automatic logic [127:0] signed_max(input int unsigned w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  // Most negative two's-complement value at width w (w <= 128); only the low w bits matter.
  function automatic logic [127:0] signed_min(input int unsigned w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational signed adder with overflow flag and optional clamp
module sat_adder
  import arith_pkg::*;
#(
  parameter int W        = ACC_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);

  localparam logic [W-1:0] MAX_POS = W'(signed_max(W));
  localparam logic [W-1:0] MIN_NEG = W'(signed_min(W));

  logic [W-1:0] raw;

  // Wrapped sum; overflow means like-signed operands produced an opposite-signed result.
  always_comb begin
    raw      = a + b;
    overflow = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum      = raw;
    if (SATURATE && overflow) begin
      sum = b[W-1] ? MIN_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - reduces blocks of signed products to one signed sum per block
module product_accumulator
  import arith_pkg::*;
#(
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   nxt;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  // in_ready comes from state alone, so out_ready never reaches it combinationally.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;

  // Sign-extend the product to accumulator width; also correct when ACC_W == PROD_W.
  assign prod_ext = ACC_W'($signed(in_product));

  // Beat counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  sat_adder #(
    .W        (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a        (acc),
    .b        (prod_ext),
    .sum      (nxt),
    .overflow (add_ovf)
  );

  // Accumulate beats, hand the finished block to the result buffer, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_sum      <= nxt;
              out_count    <= cnt_inc;
              out_overflow <= ovf | add_ovf;
              out_valid    <= 1'b1;
              acc          <= '0;
              cnt          <= '0;
              ovf          <= 1'b0;
              state        <= HOLD;
            end else begin
              acc <= nxt;
              cnt <= cnt_inc;
              ovf <= ovf | add_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
